// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the memory-access stage: size codes and MEM FSM states.
package cpu_pkg;

  localparam logic [3:0] SZ_B = 4'b0001;
  localparam logic [3:0] SZ_H = 4'b0011;
  localparam logic [3:0] SZ_W = 4'b1111;

  typedef enum logic {IDLE, WAIT} mem_state_t;

endpackage

// File: rtl/load_extend.sv
// Load-data lane selection and sign/zero extension for byte, half and word loads.
module load_extend
  import cpu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [3:0]  size,
  input  logic        us,
  output logic [31:0] result
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = rdata[{addr, 3'b000} +: 8];
  assign lane_h = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    result = rdata;
    if (size == SZ_B) begin
      result = {{24{lane_b[7] & ~us}}, lane_b};
    end else if (size == SZ_H) begin
      result = {{16{lane_h[15] & ~us}}, lane_h};
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: data-memory req/ack handshake with stall and timeout, store lane
// alignment, load extension and the MEM/WB pipeline register.
module mem_access_unit
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_mem_MemRead,
  input  logic        ex_mem_MemWrite,
  input  logic        ex_mem_RegWrite,
  input  logic        ex_mem_MemtoReg,
  input  logic        ex_mem_us,
  input  logic [3:0]  ex_mem_byte_en,
  input  logic [4:0]  ex_mem_rd,
  input  logic [31:0] ALU_result,
  input  logic [31:0] ex_mem_rd2,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        mem_wb_RegWrite,
  output logic        mem_wb_MemtoReg,
  output logic [4:0]  mem_wb_rd,
  output logic [31:0] mem_wb_load,
  output logic [31:0] mem_wb_alu
);

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        access, is_half, is_word, misaligned, timeout;
  logic        req, ack_ok, bubble;
  logic [31:0] load_data, wdata_rep;

  assign access     = ex_mem_MemRead | ex_mem_MemWrite;
  assign is_half    = (ex_mem_byte_en == SZ_H);
  assign is_word    = (ex_mem_byte_en != SZ_B) && !is_half;
  assign misaligned = access & ((is_half & ALU_result[0]) | (is_word & (|ALU_result[1:0])));
  assign timeout    = (state_q == WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req      = 1'b0;
    misalign = 1'b0;
    bus_err  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (misaligned) begin
          misalign = 1'b1;
        end else if (access) begin
          req = 1'b1;
          if (!dmem_ack) state_d = WAIT;
        end
      end
      WAIT: begin
        if (timeout) begin
          // Squash: drop the request and let the pipeline move on.
          bus_err = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          req = 1'b1;
          if (dmem_ack) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset must kill the bus request immediately, not at the next edge.
    if (!rst_n) begin
      req      = 1'b0;
      misalign = 1'b0;
      bus_err  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    wdata_rep = ex_mem_rd2;
    if (ex_mem_byte_en == SZ_B) begin
      wdata_rep = {4{ex_mem_rd2[7:0]}};
    end else if (is_half) begin
      wdata_rep = {2{ex_mem_rd2[15:0]}};
    end
  end

  assign dmem_req   = req;
  assign dmem_we    = req & ex_mem_MemWrite;
  assign dmem_addr  = req ? {ALU_result[31:2], 2'b00} : 32'd0;
  assign dmem_be    = req ? (ex_mem_byte_en << ALU_result[1:0]) : 4'd0;
  assign dmem_wdata = req ? wdata_rep : 32'd0;
  assign mem_stall  = req & ~dmem_ack;

  assign ack_ok = req & dmem_ack;
  assign bubble = misalign | mem_stall | bus_err;

  load_extend u_load_extend (
    .rdata  (dmem_rdata),
    .addr   (ALU_result[1:0]),
    .size   (ex_mem_byte_en),
    .us     (ex_mem_us),
    .result (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wb_RegWrite <= 1'b0;
      mem_wb_MemtoReg <= 1'b0;
      mem_wb_rd       <= 5'd0;
      mem_wb_load     <= 32'd0;
      mem_wb_alu      <= 32'd0;
    end else if (bubble) begin
      mem_wb_RegWrite <= 1'b0;
    end else begin
      mem_wb_RegWrite <= ex_mem_RegWrite;
      mem_wb_MemtoReg <= ex_mem_MemtoReg;
      mem_wb_rd       <= ex_mem_rd;
      mem_wb_alu      <= ALU_result;
      if (ack_ok) mem_wb_load <= load_data;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a transaction-level model
// with an ack-latency memory responder.
module tb_mem_access_unit;

  localparam int unsigned T = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_mem_MemRead, ex_mem_MemWrite, ex_mem_RegWrite, ex_mem_MemtoReg, ex_mem_us;
  logic [3:0]  ex_mem_byte_en;
  logic [4:0]  ex_mem_rd;
  logic [31:0] ALU_result, ex_mem_rd2;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        mem_stall, misalign, bus_err;
  logic        mem_wb_RegWrite, mem_wb_MemtoReg;
  logic [4:0]  mem_wb_rd;
  logic [31:0] mem_wb_load, mem_wb_alu;

  int n_cmp = 0;
  int n_bad = 0;

  // Model of the MEM/WB register contents.
  logic        m_rw, m_m2r;
  logic [4:0]  m_rd;
  logic [31:0] m_load, m_alu;

  always #5 clk = ~clk;

  mem_access_unit #(
    .TIMEOUT_CYCLES (T),
    .CNT_W          (5)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ex_mem_MemRead  (ex_mem_MemRead),
    .ex_mem_MemWrite (ex_mem_MemWrite),
    .ex_mem_RegWrite (ex_mem_RegWrite),
    .ex_mem_MemtoReg (ex_mem_MemtoReg),
    .ex_mem_us       (ex_mem_us),
    .ex_mem_byte_en  (ex_mem_byte_en),
    .ex_mem_rd       (ex_mem_rd),
    .ALU_result      (ALU_result),
    .ex_mem_rd2      (ex_mem_rd2),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_be         (dmem_be),
    .dmem_wdata      (dmem_wdata),
    .dmem_rdata      (dmem_rdata),
    .dmem_ack        (dmem_ack),
    .mem_stall       (mem_stall),
    .misalign        (misalign),
    .bus_err         (bus_err),
    .mem_wb_RegWrite (mem_wb_RegWrite),
    .mem_wb_MemtoReg (mem_wb_MemtoReg),
    .mem_wb_rd       (mem_wb_rd),
    .mem_wb_load     (mem_wb_load),
    .mem_wb_alu      (mem_wb_alu)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ext_model(input logic [31:0] rdata, input logic [31:0] addr,
                                            input int nb, input logic us);
    logic [31:0] mask, val;
    int shift;
    if (nb == 4) return rdata;
    shift = (nb == 1) ? 8 * (addr % 4) : 16 * ((addr % 4) / 2);
    mask  = (nb == 1) ? 32'hFF : 32'hFFFF;
    val   = (rdata >> shift) & mask;
    if (!us && (val > (mask >> 1))) val = val | ~mask;
    return val;
  endfunction

  task automatic check_wb(input string tag);
    check_eq({tag, ".rw"},   32'(mem_wb_RegWrite), 32'(m_rw));
    check_eq({tag, ".m2r"},  32'(mem_wb_MemtoReg), 32'(m_m2r));
    check_eq({tag, ".rd"},   32'(mem_wb_rd),       32'(m_rd));
    check_eq({tag, ".load"}, mem_wb_load,          m_load);
    check_eq({tag, ".alu"},  mem_wb_alu,           m_alu);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, ".req"},   32'(dmem_req),   0);
    check_eq({tag, ".we"},    32'(dmem_we),    0);
    check_eq({tag, ".addr"},  dmem_addr,       0);
    check_eq({tag, ".be"},    32'(dmem_be),    0);
    check_eq({tag, ".wdata"}, dmem_wdata,      0);
    check_eq({tag, ".stall"}, 32'(mem_stall),  0);
    check_eq({tag, ".mis"},   32'(misalign),   0);
    check_eq({tag, ".berr"},  32'(bus_err),    0);
  endtask

  // Entered and left at posedge+1. lat = cycles until ack (lat > T never acks).
  task automatic run_txn(input string tag, input logic r, input logic w, input logic rw,
                         input logic m2r, input logic us, input int nb, input logic [4:0] rd,
                         input logic [31:0] addr, input logic [31:0] rd2, input int lat,
                         input logic [31:0] rdata);
    logic        access, mis, completed;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    access    = r | w;
    mis       = access && ((addr % nb) != 0);
    exp_be    = 4'(((1 << nb) - 1) << (addr % 4));
    exp_wdata = (nb == 1) ? rd2[7:0] * 32'h01010101 :
                (nb == 2) ? rd2[15:0] * 32'h00010001 : rd2;
    completed = 1'b0;
    ex_mem_MemRead  = r;
    ex_mem_MemWrite = w;
    ex_mem_RegWrite = rw;
    ex_mem_MemtoReg = m2r;
    ex_mem_us       = us;
    ex_mem_byte_en  = 4'((1 << nb) - 1);
    ex_mem_rd       = rd;
    ALU_result      = addr;
    ex_mem_rd2      = rd2;
    dmem_rdata      = rdata;
    for (int k = 0; k <= int'(T) + 1; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        m_rw = 1'b0;
        check_wb({tag, ".stallwb"});
      end
      if (!access || mis || k == int'(T) + 1) dmem_ack = 1'($urandom_range(0, 1));
      else dmem_ack = (k == lat);
      @(negedge clk);
      if (!access) begin
        check_eq({tag, ".alu_req"}, 32'(dmem_req), 0);
        check_eq({tag, ".alu_stall"}, 32'(mem_stall), 0);
        completed = 1'b1;
        break;
      end
      if (mis) begin
        check_eq({tag, ".mis_req"}, 32'(dmem_req), 0);
        check_eq({tag, ".mis"}, 32'(misalign), 1);
        check_eq({tag, ".mis_stall"}, 32'(mem_stall), 0);
        break;
      end
      if (k == int'(T) + 1) begin
        check_eq({tag, ".to_req"}, 32'(dmem_req), 0);
        check_eq({tag, ".to_berr"}, 32'(bus_err), 1);
        check_eq({tag, ".to_stall"}, 32'(mem_stall), 0);
        break;
      end
      check_eq({tag, ".req"},   32'(dmem_req),  1);
      check_eq({tag, ".we"},    32'(dmem_we),   32'(w));
      check_eq({tag, ".addr"},  dmem_addr,      addr & ~32'd3);
      check_eq({tag, ".be"},    32'(dmem_be),   32'(exp_be));
      check_eq({tag, ".wdata"}, dmem_wdata,     exp_wdata);
      check_eq({tag, ".stall"}, 32'(mem_stall), 32'(k != lat));
      check_eq({tag, ".berr"},  32'(bus_err),   0);
      if (k == lat) begin
        completed = 1'b1;
        m_load    = ext_model(rdata, addr, nb, us);
        break;
      end
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    if (completed) begin
      m_rw  = rw;
      m_m2r = m2r;
      m_rd  = rd;
      m_alu = addr;
    end else begin
      m_rw = 1'b0;
    end
    check_wb({tag, ".wb"});
  endtask

  task automatic clear_inputs();
    ex_mem_MemRead  = 0; ex_mem_MemWrite = 0; ex_mem_RegWrite = 0; ex_mem_MemtoReg = 0;
    ex_mem_us = 0; ex_mem_byte_en = 4'b1111; ex_mem_rd = 0; ALU_result = 0; ex_mem_rd2 = 0;
    dmem_rdata = 0; dmem_ack = 0;
  endtask

  initial begin
    clear_inputs();
    {m_rw, m_m2r, m_rd, m_load, m_alu} = '0;
    rst_n = 1'b0;
    // A load presented during reset must not reach the bus.
    ex_mem_MemRead = 1; ex_mem_RegWrite = 1; ALU_result = 32'h100;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    check_wb("reset");
    clear_inputs();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    run_txn("lw", 1, 0, 1, 1, 0, 4, 5'd3, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    check_eq("lw_value", mem_wb_load, 32'hDEADBEEF);
    check_eq("lw_rw", 32'(mem_wb_RegWrite), 1);
    run_txn("lb", 1, 0, 1, 1, 0, 1, 5'd4, 32'h103, 32'h0, 0, 32'h80123456);
    check_eq("lb_value", mem_wb_load, 32'hFFFFFF80);
    run_txn("lbu", 1, 0, 1, 1, 1, 1, 5'd4, 32'h103, 32'h0, 1, 32'h80123456);
    check_eq("lbu_value", mem_wb_load, 32'h00000080);
    run_txn("sh", 0, 1, 0, 0, 0, 2, 5'd0, 32'h202, 32'h1234, 3, 32'h0);
    run_txn("lw_mis", 1, 0, 1, 1, 0, 4, 5'd7, 32'h101, 32'h0, 0, 32'h1);
    check_eq("mis_rw", 32'(mem_wb_RegWrite), 0);
    run_txn("alu", 0, 0, 1, 0, 0, 4, 5'd9, 32'h55AA, 32'h0, 0, 32'h0);
    run_txn("timeout", 1, 0, 1, 1, 0, 4, 5'd8, 32'h400, 32'h0, 1000, 32'h1);
    run_txn("after_to", 0, 0, 1, 0, 0, 4, 5'd10, 32'h77, 32'h0, 0, 32'h0);
    run_txn("both", 1, 1, 0, 0, 0, 4, 5'd0, 32'h500, 32'hCAFEF00D, 2, 32'h0);

    // Reset while waiting for ack.
    ex_mem_MemRead = 1; ex_mem_RegWrite = 1; ex_mem_byte_en = 4'b1111; ALU_result = 32'h300;
    dmem_ack = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rstwait.stall", 32'(mem_stall), 1);
    rst_n = 1'b0;
    #1;
    check_eq("rstwait.req", 32'(dmem_req), 0);
    check_eq("rstwait.stall0", 32'(mem_stall), 0);
    {m_rw, m_m2r, m_rd, m_load, m_alu} = '0;
    check_wb("rstwait");
    clear_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("rstrel");
    check_wb("rstrel");
    run_txn("post_rst", 1, 0, 1, 1, 0, 4, 5'd1, 32'h600, 32'h0, 0, 32'h13572468);

    // Randomized instruction stream.
    for (int i = 0; i < 200; i++) begin
      int kind, nb, lat;
      logic [31:0] addr;
      kind = $urandom_range(0, 9);
      nb   = 1 << $urandom_range(0, 2);
      addr = $urandom;
      if ($urandom_range(0, 4) != 0) addr = addr & ~(32'(nb) - 1);
      lat  = ($urandom_range(0, 49) == 0) ? 1000 : $urandom_range(0, 4);
      run_txn("rnd", kind inside {[0:3]} || kind == 9, kind inside {[4:6]} || kind == 9,
              1'($urandom), 1'($urandom), 1'($urandom), nb, 5'($urandom), addr, $urandom,
              lat, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
